stack_alu_issuer: RTL and testbench
===================================

STACK_ALU_ISSUER -- requirements
Module: stack_alu_issuer

Interface
REQ-001 SHALL have parameter N, default 8: data width, matching the downstream stack_base_alu.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: instruction FIFO entries, power of 2, 2 or more.
REQ-003 SHALL have parameter STACK_DEPTH, default 8: ALU stack capacity mirrored for depth tracking.
REQ-004 SHALL have port clk  input  1: single clock, all state on the rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1: upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1: FIFO can accept; high exactly when FIFO not full.
REQ-008 SHALL have port in_opcode  input  3: instruction opcode.
REQ-009 SHALL have port in_data  input  N: push operand; ignored for other opcodes.
REQ-010 SHALL have port alu_opcode  output  3: registered opcode to ALU.
REQ-011 SHALL have port alu_data  output  N: registered operand to ALU.
REQ-012 SHALL have port alu_overflow  input  1: ALU overflow flag.
REQ-013 SHALL have port err_clr  input  1: clears sticky flags.
REQ-014 SHALL have port err_stack  output  1: sticky, instruction dropped for stack violation.
REQ-015 SHALL have port ovf_flag  output  1: sticky, ALU reported overflow.
REQ-016 SHALL have port stack_count  output  clog2(STACK_DEPTH+1): tracked ALU stack occupancy.
REQ-017 SHALL have port busy  output  1: FIFO non-empty or FSM not in IDLE.

Function
REQ-018 SHALL use opcodes 3'b110 push, 3'b111 pop, 3'b100 add, 3'b101 multiply, 3'b0xx no-op (NOP = 3'b000).
REQ-019 SHALL write the FIFO on a rising edge with in_valid and in_ready high; NOP-class opcodes are still queued and issued.
REQ-020 SHALL run FSM IDLE -> ISSUE -> GAP; IDLE or GAP with FIFO non-empty pops one entry and enters ISSUE; GAP with FIFO empty enters IDLE.
REQ-021 SHALL drive the popped opcode/data on alu_opcode/alu_data for exactly one cycle in ISSUE, then NOP with alu_data 0 in GAP and IDLE.
REQ-022 SHALL have latency: instruction accepted at edge k on an empty, idle block is driven from edge k+1; throughput is one instruction per 2 cycles.
REQ-023 SHALL check each popped instruction: push needs stack_count < STACK_DEPTH, pop needs 1 or more, add/multiply need 2 or more.
REQ-024 SHALL, on a failed check, drive NOP in that ISSUE cycle, set err_stack, and leave stack_count unchanged.
REQ-025 SHALL update stack_count on a successful issue: push +1, pop -1, add/multiply -1, NOP 0.
REQ-026 SHALL sample alu_overflow in every GAP cycle and set ovf_flag when it is high.
REQ-027 SHALL, when err_clr is high, clear err_stack and ovf_flag; a same-cycle set wins over err_clr.
REQ-028 SHALL write and pop the FIFO in the same cycle when not full; when full, in_ready is low and no write occurs.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-030 SHALL, when rst_n is low at a rising edge, force FSM IDLE, FIFO empty, stack_count 0, alu_opcode 3'b000, alu_data 0, err_stack 0, ovf_flag 0.
REQ-031 SHALL have in_ready 1 and busy 0 on the cycle after reset.
REQ-032 SHALL, on reset mid-operation, discard queued and in-flight instructions without issuing them.

Configuration
REQ-033 SHALL, with macro STACK_ALU_ISSUER_CHECK_EN defined, implement REQ-023/REQ-024 stack checking.
REQ-034 SHALL, without the macro, issue every instruction unchecked, tie err_stack to 0, and saturate stack_count at 0 and at STACK_DEPTH.

Verification
REQ-035 SHALL cover: N=4, enqueue push 3, push 4, add -> alu_opcode 110/3, 000, 110/4, 000, 100, 000; stack_count 1, 2, 1.
REQ-036 SHALL cover: add on empty stack (macro on) -> alu_opcode stays 000, err_stack 1, stack_count 0; err_clr -> err_stack 0.
REQ-037 SHALL cover: in_valid held high with FIFO_DEPTH=8 and the FSM stalled behind queued entries -> in_ready low when the FIFO is full, no entry lost or duplicated.
REQ-038 SHALL cover: push 15, push 15, multiply (N=4), alu_overflow driven high in the following GAP -> ovf_flag 1 until err_clr.
REQ-039 SHALL cover: rst_n low during ISSUE with 3 queued entries -> next cycle alu_opcode 000, busy 0, stack_count 0, nothing further issued.
REQ-040 SHALL cover: macro off, pop on empty stack -> alu_opcode 111 issued, err_stack 0, stack_count 0.

Source files
------------

// File: rtl/stack_alu_issuer.sv
// Instruction FIFO and issue FSM feeding a stack_base_alu, with mirrored stack-depth tracking.
// Optional macro STACK_ALU_ISSUER_CHECK_EN enables stack-violation checking and err_stack.
module stack_alu_issuer #(
  parameter int unsigned N           = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_opcode,
  input  logic [N-1:0]                     in_data,
  output logic [2:0]                       alu_opcode,
  output logic [N-1:0]                     alu_data,
  input  logic                             alu_overflow,
  input  logic                             err_clr,
  output logic                             err_stack,
  output logic                             ovf_flag,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STACK_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

  state_e state_q, state_d;

  logic [2:0]    op_mem_q   [FIFO_DEPTH];
  logic [N-1:0]  data_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, do_write, do_pop;
  logic [2:0]    head_op;
  logic [N-1:0]  head_data;

  logic [CW-1:0] stack_count_q, stack_count_d, cnt_upd;
  logic          issue_ok;
  logic [2:0]    alu_opcode_q, alu_opcode_d;
  logic [N-1:0]  alu_data_q, alu_data_d;
  logic          err_q, err_d, ovf_q, ovf_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_write   = in_valid && !fifo_full;
  assign do_pop     = (state_q != S_ISSUE) && !fifo_empty;
  assign head_op    = op_mem_q[rd_ptr_q[AW-1:0]];
  assign head_data  = data_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_write) begin
      op_mem_q[wr_ptr_q[AW-1:0]]   <= in_opcode;
      data_mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAP: state_d = fifo_empty ? S_IDLE : S_ISSUE;
      S_ISSUE:       state_d = S_GAP;
      default:       state_d = S_IDLE;
    endcase
  end

  // cnt_upd is the saturating update; issue_ok gates whether it is applied.
  always_comb begin
    issue_ok = 1'b1;
    cnt_upd  = stack_count_q;
    case (head_op)
      OP_PUSH: begin
`ifdef STACK_ALU_ISSUER_CHECK_EN
        issue_ok = (stack_count_q < CNT_MAX);
`endif
        if (stack_count_q < CNT_MAX) cnt_upd = stack_count_q + 1'b1;
      end
      OP_POP: begin
`ifdef STACK_ALU_ISSUER_CHECK_EN
        issue_ok = (stack_count_q >= CW'(1));
`endif
        if (stack_count_q != '0) cnt_upd = stack_count_q - 1'b1;
      end
      OP_ADD, OP_MUL: begin
`ifdef STACK_ALU_ISSUER_CHECK_EN
        issue_ok = (stack_count_q >= CW'(2));
`endif
        if (stack_count_q != '0) cnt_upd = stack_count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_opcode_d  = OP_NOP;
    alu_data_d    = '0;
    stack_count_d = stack_count_q;
    if (do_pop && issue_ok) begin
      alu_opcode_d  = head_op;
      alu_data_d    = head_data;
      stack_count_d = cnt_upd;
    end
    err_d = (do_pop && !issue_ok) || (err_q && !err_clr);
    ovf_d = ((state_q == S_GAP) && alu_overflow) || (ovf_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stack_count_q <= '0;
      alu_opcode_q  <= OP_NOP;
      alu_data_q    <= '0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      stack_count_q <= stack_count_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_data_q    <= alu_data_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign alu_opcode  = alu_opcode_q;
  assign alu_data    = alu_data_q;
  assign stack_count = stack_count_q;
  assign ovf_flag    = ovf_q;
  assign busy        = !fifo_empty || (state_q != S_IDLE);
`ifdef STACK_ALU_ISSUER_CHECK_EN
  assign err_stack   = err_q;
`else
  assign err_stack   = 1'b0;
`endif

endmodule

// File: tb/tb_stack_alu_issuer.sv
// Scoreboard bench for stack_alu_issuer: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_stack_alu_issuer;
  localparam int unsigned N  = 4;
  localparam int unsigned FD = 8;
  localparam int unsigned SD = 8;
  localparam int unsigned CW = $clog2(SD + 1);
`ifdef STACK_ALU_ISSUER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = 3'b000;
  logic [N-1:0]  in_data = '0;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic          alu_overflow = 1'b0;
  logic          err_clr = 1'b0;
  logic          err_stack;
  logic          ovf_flag;
  logic [CW-1:0] stack_count;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_alu_issuer #(.N(N), .FIFO_DEPTH(FD), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_data(in_data), .alu_opcode(alu_opcode),
    .alu_data(alu_data), .alu_overflow(alu_overflow), .err_clr(err_clr),
    .err_stack(err_stack), .ovf_flag(ovf_flag), .stack_count(stack_count),
    .busy(busy)
  );

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] data;
    int           cnt;
    bit           err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_cnt = 0;
  bit   m_err = 1'b0;
  bit   mon_en = 1'b0;
  int   low_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Instruction-level model: what the ALU should see for each accepted instruction, in order.
  function automatic exp_t model_step(input logic [2:0] op, input logic [N-1:0] data);
    exp_t e;
    bit   ok;
    int   nxt;
    if (op == 3'b110)      ok = (m_cnt < SD);
    else if (op == 3'b111) ok = (m_cnt >= 1);
    else if (op[2])        ok = (m_cnt >= 2);
    else                   ok = 1'b1;
    if (op == 3'b110)      nxt = (m_cnt < SD) ? m_cnt + 1 : m_cnt;
    else if (op[2])        nxt = (m_cnt > 0) ? m_cnt - 1 : 0;
    else                   nxt = m_cnt;
    if (CHK_EN && !ok) begin
      e.op   = 3'b000;
      e.data = '0;
      m_err  = 1'b1;
    end else begin
      e.op   = op;
      e.data = data;
      m_cnt  = nxt;
    end
    e.cnt = m_cnt;
    e.err = m_err;
    return e;
  endfunction

  // Monitor: every visible issue retires the next non-NOP expectation.
  initial forever begin
    @(negedge clk);
    if (mon_en && alu_opcode != 3'b000) begin
      while (sb.size() > 0 && sb[0].op == 3'b000) void'(sb.pop_front());
      if (sb.size() == 0) begin
        chk("unexpected_issue", int'(alu_opcode), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_op", int'(alu_opcode), int'(mon_e.op));
        chk("issue_data", int'(alu_data), int'(mon_e.data));
        chk("issue_count", int'(stack_count), mon_e.cnt);
        chk("issue_err", int'(err_stack), int'(mon_e.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; alu_overflow = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    sb.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic send_one(input logic [2:0] op, input logic [N-1:0] d);
    in_valid = 1'b1; in_opcode = op; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drive_rand(input int ncyc, input int pct, input bit burst);
    bit hold = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (!hold) begin
        in_valid  = burst || ($urandom_range(0, 99) < pct);
        in_opcode = ($urandom_range(0, 2) == 0) ? 3'b110 : 3'($urandom_range(0, 7));
        in_data   = N'($urandom);
      end
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) sb.push_back(model_step(in_opcode, in_data));
      if (!in_ready) low_seen++;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    bit quiet_bad;
    cyc();
    do_reset();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_opcode", int'(alu_opcode), 0);
    chk("rst_data", int'(alu_data), 0);
    chk("rst_count", int'(stack_count), 0);
    chk("rst_err", int'(err_stack), 0);
    chk("rst_ovf", int'(ovf_flag), 0);

    // push 3, push 4, add back-to-back: one issue every other cycle from edge k+1
    in_valid = 1'b1; in_opcode = 3'b110; in_data = 4'd3;
    cyc();
    in_data = 4'd4;
    cyc();
    chk("seq_op0", int'(alu_opcode), 6); chk("seq_d0", int'(alu_data), 3); chk("seq_c0", int'(stack_count), 1);
    in_opcode = 3'b100; in_data = '0;
    cyc();
    in_valid = 1'b0;
    chk("seq_op1", int'(alu_opcode), 0); chk("seq_c1", int'(stack_count), 1);
    cyc();
    chk("seq_op2", int'(alu_opcode), 6); chk("seq_d2", int'(alu_data), 4); chk("seq_c2", int'(stack_count), 2);
    cyc();
    chk("seq_op3", int'(alu_opcode), 0);
    cyc();
    chk("seq_op4", int'(alu_opcode), 4); chk("seq_c4", int'(stack_count), 1);
    cyc();
    chk("seq_op5", int'(alu_opcode), 0); chk("seq_busy5", int'(busy), 1);
    cyc();
    chk("seq_idle_busy", int'(busy), 0);

    // stack violations on an empty stack
    do_reset();
    send_one(3'b100, '0);
    cyc();
    chk("empty_add_op", int'(alu_opcode), CHK_EN ? 0 : 4);
    chk("empty_add_err", int'(err_stack), CHK_EN ? 1 : 0);
    chk("empty_add_count", int'(stack_count), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_clr", int'(err_stack), 0);
    send_one(3'b111, '0);
    cyc();
    chk("empty_pop_op", int'(alu_opcode), CHK_EN ? 0 : 7);
    chk("empty_pop_err", int'(err_stack), CHK_EN ? 1 : 0);
    chk("empty_pop_count", int'(stack_count), 0);

    // overflow captured in the GAP after a multiply, sticky until err_clr
    do_reset();
    in_valid = 1'b1; in_opcode = 3'b110; in_data = 4'hF;
    cyc();
    cyc();
    in_opcode = 3'b101; in_data = '0;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && alu_opcode != 3'b101; i++) cyc();
    chk("mul_issue", int'(alu_opcode), 5);
    chk("mul_count", int'(stack_count), 1);
    cyc();
    alu_overflow = 1'b1;
    chk("ovf_before_gap", int'(ovf_flag), 0);
    cyc();
    alu_overflow = 1'b0;
    chk("ovf_set", int'(ovf_flag), 1);
    cyc(3);
    chk("ovf_sticky", int'(ovf_flag), 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ovf_cleared", int'(ovf_flag), 0);
    send_one(3'b000, '0);
    cyc();
    alu_overflow = 1'b1;
    cyc();
    chk("ovf_not_in_issue", int'(ovf_flag), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; alu_overflow = 1'b0;
    chk("ovf_set_wins", int'(ovf_flag), 1);

    // reset during ISSUE with three entries still queued
    do_reset();
    in_valid = 1'b1; in_opcode = 3'b110;
    for (int i = 1; i <= 6; i++) begin
      in_data = N'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_op", int'(alu_opcode), 6);
    chk("pre_rst_data", int'(alu_data), 3);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_op", int'(alu_opcode), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(stack_count), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (alu_opcode != 3'b000 || busy) quiet_bad = 1'b1;
    end
    chk("post_rst_quiet", int'(quiet_bad), 0);

    // randomized traffic, starting with a held-valid burst that fills the FIFO
    do_reset();
    mon_en = 1'b1;
    low_seen = 0;
    drive_rand(40, 100, 1'b1);
    chk("burst_full_seen", int'(low_seen > 0), 1);
    drive_rand(600, 60, 1'b0);
    for (int i = 0; i < 300 && busy; i++) cyc();
    chk("drain_busy", int'(busy), 0);
    cyc(2);
    while (sb.size() > 0 && sb[0].op == 3'b000) void'(sb.pop_front());
    chk("sb_leftover", sb.size(), 0);
    chk("final_count", int'(stack_count), m_cnt);
    chk("final_err", int'(err_stack), int'(m_err));
    chk("final_ovf", int'(ovf_flag), 0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
